multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main FSM for the multi-cycle RV32I core. Sequences the shared ALU, register file, PC and unified
//  instruction/data memory one phase per state; drives alu_op to ALUControl (00=add, 01=sub compare,
//  10=funct3-decoded). Supports LW, SW, R-type, I-type ALU, BEQ and JAL. Memory phases stall on mem_ready.
// PARAMETERS
//  OP_LW=7'b0000011  OP_SW=7'b0100011  OP_R=7'b0110011  OP_I=7'b0010011  OP_BEQ=7'b1100011  OP_JAL=7'b1101111
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  asynchronous, active-high reset
//  opcode         in   7  IR[6:0], valid from DECODE onward
//  zero           in   1  ALU zero flag, sampled in BRANCH
//  mem_ready      in   1  memory completes current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load qualified by zero
//  ir_write       out  1  load IR from memory read data
//  iord           out  1  memory address select: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  reg_write      out  1  register-file write enable
//  mem_to_reg     out  2  rd source: 00=ALUOut, 01=MDR, 10=PC (link)
//  alu_src_a      out  2  00=PC, 01=rs1 reg A, 10=old PC (OldPC register)
//  alu_src_b      out  2  00=reg B, 01=const 4, 10=immediate
//  alu_op         out  2  to ALUControl
//  pc_source      out  2  00=ALU result, 01=ALUOut
//  state_dbg      out  4  current state encoding
// BEHAVIOUR
//  - States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JAL=9 TRAP=10.
//  - rst high: state<=FETCH immediately; every output forced 0 while rst high. First fetch the cycle after release.
//  - Outputs decoded from state; only listed signals nonzero, all others 0.
//  - FETCH: iord=0, mem_read=1, alu_src_a=00, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready.
//    Stay while mem_ready=0 (request held, no PC/IR update); ->DECODE on mem_ready=1.
//  - DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch/jump target to ALUOut). Next by opcode:
//    LW/SW->MEMADR, R/I->EXEC, BEQ->BRANCH, JAL->JAL, other->TRAP (or FETCH, see CONFIGURATION).
//  - MEMADR: alu_src_a=01, alu_src_b=10, alu_op=00. ->MEMRD if LW, ->MEMWR if SW.
//  - MEMRD: iord=1, mem_read=1; hold until mem_ready, then ->MEMWB. MEMWB: reg_write=1, mem_to_reg=01; ->FETCH.
//  - MEMWR: iord=1, mem_write=1; hold until mem_ready, then ->FETCH. Exactly one cycle with mem_ready=1 per access.
//  - EXEC: alu_src_a=01, alu_op=10, alu_src_b=00 if R else 10. ->ALUWB. ALUWB: reg_write=1, mem_to_reg=00; ->FETCH.
//  - BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH.
//  - JAL: pc_write=1, pc_source=01, reg_write=1, mem_to_reg=10 (rd=PC+4 already in PC); ->FETCH.
//  - TRAP: all control outputs 0; absorbing until rst.
//  - CPI: R/I=4, BEQ=3, JAL=3, SW=4, LW=5 with zero-wait memory; each mem_ready=0 cycle adds one.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored. rst mid-access drops the request the same cycle.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode in DECODE ->TRAP; extra output illegal_insn (1 bit) is
//   registered, set on entry to TRAP, cleared only by rst; state_dbg reads 10.
//  ILLEGAL_TRAP_EN undefined: unknown opcode ->FETCH (executes as NOP, 2 cycles); no TRAP state,
//   no illegal_insn port.
// TESTING
//  1. rst=1 then release, mem_ready=1: all outputs 0 during rst; next cycle state_dbg=0, mem_read=1, pc_write=1, ir_write=1.
//  2. opcode=0110011, mem_ready=1: states 0,1,6,7,0; alu_op=10 in EXEC with alu_src_b=00; reg_write=1 only in ALUWB.
//  3. opcode=0000011, mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles, mem_read=1, iord=1 throughout; total 8 cycles.
//  4. opcode=1100011, zero=1 then zero=0: BRANCH gives pc_write_cond=1, alu_op=01, pc_source=01; 3 cycles both cases.
//  5. opcode=1101111: JAL state pc_write=1, reg_write=1, mem_to_reg=10; back to FETCH next cycle.
//  6. opcode=1111111: with ILLEGAL_TRAP_EN, state_dbg=10, illegal_insn=1 persists until rst; without, FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle RV32I main FSM and its datapath.
//   master : the control FSM (reads opcode/zero/mem_ready, drives every control strobe)
//   slave  : the datapath side (drives opcode/zero/mem_ready, consumes the strobes)
// Optional macro ILLEGAL_TRAP_EN adds the illegal_insn flag to the bundle.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state_dbg;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_insn;
`endif

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, state_dbg
`ifdef ILLEGAL_TRAP_EN
    , output illegal_insn
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, state_dbg
`ifdef ILLEGAL_TRAP_EN
    , input illegal_insn
`endif
  );
endinterface

// File: rtl/multicycle_control.sv
// Main FSM of the multi-cycle RV32I core (LW, SW, R-type, I-type ALU, BEQ, JAL).
// One datapath phase per state; memory phases stall on mem_ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, forces every output to 0 while high
//   ctrl : multicycle_control_if.master (opcode/zero/mem_ready in, control strobes out)
// Optional feature macro ILLEGAL_TRAP_EN: unknown opcodes enter an absorbing TRAP state and
// raise illegal_insn; otherwise they retire as a 2-cycle NOP.
module multicycle_control (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_control_if.master           ctrl
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJal    = 4'd9
`ifdef ILLEGAL_TRAP_EN
    , StTrap = 4'd10
`endif
  } state_e;

  state_e state_q;
`ifdef ILLEGAL_TRAP_EN
  logic   illegal_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFetch:  if (ctrl.mem_ready) state_q <= StDecode;
        StDecode: begin
          unique case (ctrl.opcode)
            OP_LW, OP_SW: state_q <= StMemAdr;
            OP_R, OP_I:   state_q <= StExec;
            OP_BEQ:       state_q <= StBranch;
            OP_JAL:       state_q <= StJal;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_q   <= StTrap;
              illegal_q <= 1'b1;
`else
              state_q   <= StFetch;
`endif
            end
          endcase
        end
        StMemAdr: state_q <= (ctrl.opcode == OP_LW) ? StMemRd : StMemWr;
        StMemRd:  if (ctrl.mem_ready) state_q <= StMemWb;
        StMemWb:  state_q <= StFetch;
        StMemWr:  if (ctrl.mem_ready) state_q <= StFetch;
        StExec:   state_q <= StAluWb;
        StAluWb:  state_q <= StFetch;
        StBranch: state_q <= StFetch;
        StJal:    state_q <= StFetch;
`ifdef ILLEGAL_TRAP_EN
        StTrap:   state_q <= StTrap;
`endif
        default:  state_q <= StFetch;
      endcase
    end
  end

  // Moore decode of the state register; FETCH alone also looks at mem_ready so the PC/IR update
  // only on the cycle the read completes. Everything is gated by rst so a request in flight drops
  // in the same cycle reset rises.
  always_comb begin
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.iord          = 1'b0;
    ctrl.mem_read      = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.mem_to_reg    = 2'b00;
    ctrl.alu_src_a     = 2'b00;
    ctrl.alu_src_b     = 2'b00;
    ctrl.alu_op        = 2'b00;
    ctrl.pc_source     = 2'b00;
    ctrl.state_dbg     = 4'd0;
    if (!rst) begin
      ctrl.state_dbg = state_q;
      unique case (state_q)
        StFetch: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.ir_write  = ctrl.mem_ready;
          ctrl.pc_write  = ctrl.mem_ready;
        end
        StDecode: begin
          // OldPC + imm lands in ALUOut as the branch/jump target
          ctrl.alu_src_a = 2'b10;
          ctrl.alu_src_b = 2'b10;
        end
        StMemAdr: begin
          ctrl.alu_src_a = 2'b01;
          ctrl.alu_src_b = 2'b10;
        end
        StMemRd: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        StMemWb: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 2'b01;
        end
        StMemWr: begin
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        StExec: begin
          ctrl.alu_src_a = 2'b01;
          ctrl.alu_op    = 2'b10;
          ctrl.alu_src_b = (ctrl.opcode == OP_R) ? 2'b00 : 2'b10;
        end
        StAluWb: ctrl.reg_write = 1'b1;
        StBranch: begin
          ctrl.alu_src_a     = 2'b01;
          ctrl.alu_op        = 2'b01;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = 2'b01;
        end
        StJal: begin
          // PC already holds PC+4 from FETCH, so it is the link value
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = 2'b01;
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 2'b10;
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign ctrl.illegal_insn = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by state and checks
// state_dbg plus the full control vector against hand-written per-state constants.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write,
  //  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [16:0] C_NONE  = '0;
  localparam logic [16:0] C_FRDY  = {7'b1010100, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
  localparam logic [16:0] C_FWAIT = {7'b0000100, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
  localparam logic [16:0] C_DEC   = {7'b0000000, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
  localparam logic [16:0] C_MADR  = {7'b0000000, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
  localparam logic [16:0] C_MRD   = {7'b0001100, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [16:0] C_MWB   = {7'b0000001, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [16:0] C_MWR   = {7'b0001010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [16:0] C_EXR   = {7'b0000000, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
  localparam logic [16:0] C_EXI   = {7'b0000000, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
  localparam logic [16:0] C_AWB   = {7'b0000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [16:0] C_BR    = {7'b0100000, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
  localparam logic [16:0] C_JAL   = {7'b1000001, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1};

  function automatic logic [16:0] ctl_now();
    return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord, bus.mem_read,
            bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_source};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply mem_ready for this cycle, check state and controls, then advance one clock.
  task automatic step(input string tag, input logic mr, input logic [3:0] st,
                      input logic [16:0] c);
    bus.mem_ready = mr;
    #1;
    check_eq({tag, ".state"}, {28'd0, bus.state_dbg}, {28'd0, st});
    check_eq({tag, ".ctl"}, {15'd0, ctl_now()}, {15'd0, c});
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.opcode    = 7'b0110011;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset: everything low even though FETCH with mem_ready=1 would drive strobes
    @(posedge clk);
    #2;
    check_eq("rst.ctl", {15'd0, ctl_now()}, 32'd0);
    check_eq("rst.state", {28'd0, bus.state_dbg}, 32'd0);
    rst = 1'b0;

    // R-type: 4 cycles
    bus.opcode = 7'b0110011;
    step("r.fetch", 1'b1, 4'd0, C_FRDY);
    step("r.dec",   1'b0, 4'd1, C_DEC);   // mem_ready ignored in DECODE
    step("r.exec",  1'b1, 4'd6, C_EXR);
    step("r.wb",    1'b1, 4'd7, C_AWB);

    // I-type with one fetch wait cycle
    bus.opcode = 7'b0010011;
    step("i.fwait", 1'b0, 4'd0, C_FWAIT);
    step("i.fetch", 1'b1, 4'd0, C_FRDY);
    step("i.dec",   1'b1, 4'd1, C_DEC);
    step("i.exec",  1'b1, 4'd6, C_EXI);
    step("i.wb",    1'b1, 4'd7, C_AWB);

    // LW with 3 wait cycles in MEMRD: 8 cycles total
    bus.opcode = 7'b0000011;
    step("lw.fetch", 1'b1, 4'd0, C_FRDY);
    step("lw.dec",   1'b1, 4'd1, C_DEC);
    step("lw.adr",   1'b1, 4'd2, C_MADR);
    for (int i = 0; i < 3; i++) step("lw.rdwait", 1'b0, 4'd3, C_MRD);
    step("lw.rd",    1'b1, 4'd3, C_MRD);
    step("lw.wb",    1'b1, 4'd4, C_MWB);

    // SW zero-wait: 4 cycles
    bus.opcode = 7'b0100011;
    step("sw.fetch", 1'b1, 4'd0, C_FRDY);
    step("sw.dec",   1'b1, 4'd1, C_DEC);
    step("sw.adr",   1'b1, 4'd2, C_MADR);
    step("sw.wr",    1'b1, 4'd5, C_MWR);

    // BEQ taken then not taken: 3 cycles each
    bus.opcode = 7'b1100011;
    for (int z = 1; z >= 0; z--) begin
      bus.zero = z[0];
      step("beq.fetch", 1'b1, 4'd0, C_FRDY);
      step("beq.dec",   1'b1, 4'd1, C_DEC);
      #1;
      check_eq("beq.taken", {31'd0, bus.pc_write_cond & bus.zero}, {31'd0, z[0]});
      step("beq.br",    1'b1, 4'd8, C_BR);
    end

    // JAL: 3 cycles
    bus.opcode = 7'b1101111;
    step("jal.fetch", 1'b1, 4'd0, C_FRDY);
    step("jal.dec",   1'b1, 4'd1, C_DEC);
    step("jal.jal",   1'b1, 4'd9, C_JAL);
    step("jal.next",  1'b1, 4'd0, C_FRDY);   // back in FETCH (then decodes JAL again)
    step("jal.dec2",  1'b1, 4'd1, C_DEC);
    step("jal.jal2",  1'b1, 4'd9, C_JAL);

    // Reset mid-access drops the read request immediately
    bus.opcode = 7'b0000011;
    step("mid.fetch", 1'b1, 4'd0, C_FRDY);
    step("mid.dec",   1'b1, 4'd1, C_DEC);
    step("mid.adr",   1'b1, 4'd2, C_MADR);
    bus.mem_ready = 1'b0;
    #1;
    check_eq("mid.rd", {28'd0, bus.state_dbg}, 32'd3);
    rst = 1'b1;
    #1;
    check_eq("mid.rst.ctl", {15'd0, ctl_now()}, 32'd0);
    check_eq("mid.rst.state", {28'd0, bus.state_dbg}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Unknown opcode
    bus.opcode = 7'b1111111;
    step("ill.fetch", 1'b1, 4'd0, C_FRDY);
    step("ill.dec",   1'b1, 4'd1, C_DEC);
`ifdef ILLEGAL_TRAP_EN
    check_eq("ill.flag0", {31'd0, bus.illegal_insn}, 32'd1);
    for (int i = 0; i < 3; i++) step("ill.trap", 1'b1, 4'd10, C_NONE);
    check_eq("ill.flag1", {31'd0, bus.illegal_insn}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("ill.clr", {31'd0, bus.illegal_insn}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.opcode = 7'b0110011;
    step("ill.refetch", 1'b1, 4'd0, C_FRDY);
`else
    step("ill.nop",   1'b1, 4'd0, C_FRDY);
    bus.opcode = 7'b0110011;
    step("ill.dec2",  1'b1, 4'd1, C_DEC);
    step("ill.exec",  1'b1, 4'd6, C_EXR);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
